kgp_control_sequencer: RTL
==========================

// Module: kgp_control_sequencer
// PURPOSE
//   Multi-cycle fetch/decode/control FSM for the KGP-RISC datapath. It sits directly
//   upstream of the register bank, the ALU and the writeback mux. It fetches 32-bit
//   instructions from a synchronous instruction ROM and drives sr1/sr2/dr/write/sel,
//   ALU mode/en and the immediate write data. Each non-halt instruction takes 4 cycles.
// PARAMETERS
//   ADDR_W    8   width of the program counter / instruction address (words)
//   RESET_PC  0   PC value loaded on reset
// PORTS
//   clk         in   1       system clock, all state updates on posedge
//   reset       in   1       synchronous, active-high reset
//   start       in   1       in IDLE, begin execution at the current PC
//   instr_addr  out  ADDR_W  ROM address (= pc); ROM returns data 1 cycle later
//   instr_data  in   32      ROM read data
//   sr1, sr2    out  5       register bank read selects
//   dr          out  5       register bank write select
//   write       out  1       register bank write enable (1-cycle pulse)
//   sel         out  1       mux select: 0 = ALU result, 1 = imm_data
//   imm_data    out  32      sign-extended immediate for the mux b input
//   mode        out  4       ALU operation select
//   en          out  1       ALU enable
//   busy        out  1       high in every state except IDLE and HALTED
//   halted      out  1       high in HALTED
//   illegal     out  1       1-cycle pulse on an undefined opcode
// BEHAVIOUR
//   Encoding: op=[31:26] rs=[25:21] rt=[20:16] rd=[15:11] func=[10:7] imm=[15:0].
//     op 000000 ALU: sr1=rs, sr2=rt, dr=rd, mode=func, sel=0.
//     op 000001 LI:  dr=rt, imm_data=sext(imm), sel=1, en=0.
//     op 000010 JMP: pc <= instr[ADDR_W-1:0]; no register write.
//     op 111111 HALT. All other opcodes: NOP, with illegal pulsed in DECODE.
//   States: IDLE -> FETCH -> DECODE -> EXEC -> WB -> FETCH. HALT goes DECODE -> HALTED.
//   IDLE: wait for start; start=1 moves to FETCH on the next edge.
//   FETCH: instr_addr=pc. DECODE: ir <= instr_data; sr1/sr2/dr/mode/sel/imm_data
//     are registered from ir and held stable through EXEC and WB.
//   EXEC: en=1 for ALU ops. WB: en stays 1; write=1 only for ALU and LI ops.
//   PC update at the WB edge: pc+1, or the jump target for JMP.
//   PC arithmetic is modulo 2^ADDR_W; increment wraps from all-ones to 0.
//   HALTED: all strobes are 0, halted=1, start is ignored. Only reset exits.
//   Reset, asserted in any state including mid-instruction: on that edge
//     state=IDLE, pc=RESET_PC, and write/en/sel/illegal/busy/halted=0.
//     sr1/sr2/dr/mode=0 and imm_data=0. No partial write may occur in the reset cycle.
//   reset and start asserted together: reset wins.
//   write never asserts outside WB; write and illegal never assert in the same cycle.
// CONFIGURATION
//   KGP_SEQ_PERF_EN defined: adds output retired_cnt[31:0].
//     It increments at each WB edge, saturates at 32'hFFFF_FFFF, and clears on reset.
//   KGP_SEQ_PERF_EN undefined: no port and no counter logic. All other behaviour is identical.
// TESTING
//   1. reset, start, ROM[0]=LI r1,370 -> WB cycle 4 after FETCH: write=1, dr=1, sel=1,
//      imm_data=370.
//   2. LI r1,370; LI r2,4; ALU r3=r1 op0 r2 -> third WB: write=1, dr=3, sr1=1, sr2=2,
//      mode=0, sel=0, en=1.
//   3. JMP to 8x at pc=0x05 with ADDR_W=8 -> next instr_addr=0x08, write=0 throughout.
//      Also run pc=0xFF with a non-JMP -> wraps to 0x00.
//   4. Opcode 010101 -> illegal=1 for exactly one cycle in DECODE, no write, pc advances by 1.
//   5. HALT -> halted=1, busy=0; start pulses are ignored; reset -> IDLE, pc=RESET_PC.
//   6. reset asserted in EXEC of an ALU op -> no write on the following cycles.
//      With PERF_EN: retired_cnt=0 after reset, and 3 after test 2.

Source files
------------

// File: rtl/kgp_control_sequencer.sv
// Multi-cycle fetch/decode/control sequencer for the KGP-RISC datapath.
// Optional retired-instruction counter: define KGP_SEQ_PERF_EN to add retired_cnt.
module kgp_control_sequencer #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [31:0]       instr_data,
  output logic [4:0]        sr1,
  output logic [4:0]        sr2,
  output logic [4:0]        dr,
  output logic              write,
  output logic              sel,
  output logic [31:0]       imm_data,
  output logic [3:0]        mode,
  output logic              en,
  output logic              busy,
  output logic              halted,
  output logic              illegal,
`ifdef KGP_SEQ_PERF_EN
  output logic [31:0]       retired_cnt,
`endif
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd5
  } state_e;

  localparam logic [5:0] OP_ALU  = 6'b000000;
  localparam logic [5:0] OP_LI   = 6'b000001;
  localparam logic [5:0] OP_JMP  = 6'b000010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;

  logic [5:0] ir_op;
  logic [5:0] dec_op;
  logic       is_alu, is_li, is_jmp, dec_legal;

  assign ir_op     = ir_q[31:26];
  assign dec_op    = instr_data[31:26];
  assign is_alu    = (ir_op == OP_ALU);
  assign is_li     = (ir_op == OP_LI);
  assign is_jmp    = (ir_op == OP_JMP);
  assign dec_legal = (dec_op == OP_ALU) || (dec_op == OP_LI) ||
                     (dec_op == OP_JMP) || (dec_op == OP_HALT);

  // start is a level sampled only in IDLE; there is no ready/ack back to the source.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (dec_op == OP_HALT) begin
          state_d = S_HALTED;
        end else begin
          ir_d    = instr_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC:   state_d = S_WB;
      S_WB: begin
        pc_d    = is_jmp ? ir_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
        state_d = S_FETCH;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Datapath selects come straight from the latched instruction, so they stay
  // stable from EXEC through WB; strobes are masked by reset to avoid a partial write.
  always_comb begin
    instr_addr = pc_q;
    sr1        = ir_q[25:21];
    sr2        = ir_q[20:16];
    dr         = is_li ? ir_q[20:16] : ir_q[15:11];
    mode       = ir_q[10:7];
    sel        = is_li;
    imm_data   = {{16{ir_q[15]}}, ir_q[15:0]};
    en         = !reset && is_alu && ((state_q == S_EXEC) || (state_q == S_WB));
    write      = !reset && (is_alu || is_li) && (state_q == S_WB);
    illegal    = !reset && (state_q == S_DECODE) && !dec_legal;
    busy       = (state_q != S_IDLE) && (state_q != S_HALTED);
    halted     = (state_q == S_HALTED);
    dbg_state  = state_q;
  end

`ifdef KGP_SEQ_PERF_EN
  logic [31:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if ((state_q == S_WB) && (retired_q != 32'hFFFF_FFFF)) retired_d = retired_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) retired_q <= '0;
    else       retired_q <= retired_d;
  end

  assign retired_cnt = retired_q;
`endif

endmodule
